frame_wr_buf: RTL and testbench
===============================

Name: frame_wr_buf

Overview:
- DDR write-side line requester: the write-path counterpart of the rotation read buffer.
- Accepts a pixel stream in the ddr_clk domain and packs pixels into 256-bit DDR beats.
- Buffers whole lines in ping-pong banks and issues one DDR write burst per line into the current frame half.
- Sits between the video-input CDC and the DDR write arbiter; the rotation reader consumes what it writes.

Parameters:
- ADDR_WIDTH, 27, DDR address width (32-bit word units).
- ADDR_OFFSET, 32'h0000_0000, base added to every write address.
- H_NUM, 640, pixels per line.
- V_NUM, 480, lines per frame.
- DQ_WIDTH, 32, DDR DQ width; beat width = 8*DQ_WIDTH.
- LEN_WIDTH, 16, burst-length field width.
- PIX_WIDTH, 16, bits per pixel.
- LINE_ADDR_WIDTH, 22, in-frame address width.
- FRAME_CNT_WIDTH, 8, frame counter width.

Ports:
- ddr_clk  in  1  sole clock.
- ddr_rst  in  1  synchronous, active-high reset.
- pix_vs  in  1  frame sync, rising edge = new frame.
- pix_de  in  1  pixel valid.
- pix_data  in  PIX_WIDTH  pixel.
- ddr_part_wr  in  2  partition select, inserted into the address.
- ddr_waddr  out  ADDR_WIDTH  burst start address.
- ddr_wr_len  out  LEN_WIDTH  beats per burst.
- ddr_wr_req  out  1  burst request.
- ddr_wdata_req  in  1  controller requests next beat.
- ddr_wdata  out  8*DQ_WIDTH  beat data.
- ddr_wdone  in  1  burst complete pulse.
- wr_frame_cnt  out  FRAME_CNT_WIDTH  completed frames.
- overflow  out  1  sticky line-drop flag.

Behaviour:
- Derived constants:
  - BEAT_PIX = 8*DQ_WIDTH/PIX_WIDTH (16 at defaults).
  - LINE_BEATS = H_NUM/BEAT_PIX (40).
  - LINE_STRIDE = LINE_BEATS*8 (320, in 32-bit units).
- Reset (synchronous, ddr_rst=1): all outputs and state go to 0.
  - ddr_wr_req=0, ddr_wdata=0, ddr_waddr=ADDR_OFFSET, wr_frame_cnt=0, overflow=0.
  - FSM returns to IDLE; both banks are marked empty.
  - Reset mid-burst abandons the burst; no ddr_wdone is awaited.
- ddr_wr_len is constant LINE_BEATS.
- Packing:
  - Each pix_de pixel goes into the current beat, pixel k of the beat at bits [k*PIX_WIDTH +: PIX_WIDTH] (LSB first).
  - Every BEAT_PIX pixels one beat is written to the fill bank.
  - After LINE_BEATS beats the fill bank is marked full and filling switches to the other bank.
- Banks: 2 x LINE_BEATS x 256-bit RAM.
  - If the next fill bank is still full when a line completes, that line is discarded: overflow is set (sticky until reset), the in-line pixel and beat counters still advance, and no bank flip occurs.
- pix_vs rising edge:
  - Clears the pixel, beat and input-line counters.
  - Discards a partially filled line.
  - Full banks remain pending and are still written.
- FSM (IDLE, REQ, BURST, DONE):
  - IDLE: if the drain bank is full, latch ddr_waddr = {wr_frame_cnt[0], ddr_part_wr, line_idx*LINE_STRIDE} + ADDR_OFFSET, then go to REQ.
  - REQ: ddr_wr_req=1 until the first ddr_wdata_req, then go to BURST.
  - BURST: each ddr_wdata_req cycle advances the read pointer. ddr_wdata is valid exactly 1 cycle after the ddr_wdata_req (registered RAM read); beats are presented in order 0..LINE_BEATS-1. On ddr_wdone: ddr_wr_req=0, go to DONE.
  - DONE (1 cycle): mark the bank empty, flip the drain bank, increment line_idx.
    - If line_idx was V_NUM-1: line_idx=0 and wr_frame_cnt increments (wraps).
    - Go to IDLE.
  - ddr_wdata_req outside BURST/REQ is ignored.
  - More than LINE_BEATS requests hold the pointer at the last beat.
- Simultaneous events:
  - A line completing in the same cycle as DONE frees that bank: the bank is treated as empty, so no overflow.
  - pix_vs during BURST does not affect the burst.
- Latency: a line is complete to ddr_wr_req=1 in 2 cycles when IDLE.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined: pix_data is ignored; each accepted pixel is replaced by {input_line_idx[7:0], x_idx[7:0]}, zero-extended/truncated to PIX_WIDTH. Timing is still taken from pix_de and pix_vs.
- Undefined: pix_data is used unchanged.

Test Plan:
- Reset, then one full line of pix_data = x index; controller asserts ddr_wdata_req continuously → ddr_wr_req rises 2 cycles after the 640th pixel, ddr_waddr=ADDR_OFFSET, 40 beats, beat 0 = pixels 0..15 LSB first, ddr_wr_req low after ddr_wdone.
- 480 lines with ddr_part_wr=2'b01 → line 1 ddr_waddr=0x40_0000|320; after the 480th ddr_wdone, wr_frame_cnt=1; the next line address has bit 24 set and the in-frame offset is 0.
- Controller stalls (no ddr_wdata_req) while 3 lines arrive → overflow=1, the third line is dropped, and the first two lines are written correctly once the controller resumes.
- ddr_wdata_req in sparse single-cycle pulses → each ddr_wdata is updated exactly 1 cycle after its request, with beat order intact.
- pix_vs pulse mid-line (after 300 pixels) → the partial line is discarded and the next line starts at x=0; the previously full bank is still written.
- ddr_rst asserted during BURST → next cycle ddr_wr_req=0, wr_frame_cnt=0, overflow=0; the next line is written at ADDR_OFFSET. With TEST_PATTERN_EN, beat 0 of line 3 is 0x030F...0x0300.

Source files
------------

// File: rtl/frame_wr_buf.sv
// DDR write-side line buffer: packs pixels into beats, ping-pong line banks, one burst per line.
// Optional TEST_PATTERN_EN replaces pixel data with {line[7:0], x[7:0]}.
module frame_wr_buf #(
  parameter int          ADDR_WIDTH      = 27,
  parameter logic [31:0] ADDR_OFFSET     = 32'h0000_0000,
  parameter int          H_NUM           = 640,
  parameter int          V_NUM           = 480,
  parameter int          DQ_WIDTH        = 32,
  parameter int          LEN_WIDTH       = 16,
  parameter int          PIX_WIDTH       = 16,
  parameter int          LINE_ADDR_WIDTH = 22,
  parameter int          FRAME_CNT_WIDTH = 8
) (
  input  logic                       ddr_clk,
  input  logic                       ddr_rst,
  input  logic                       pix_vs,
  input  logic                       pix_de,
  input  logic [PIX_WIDTH-1:0]       pix_data,
  input  logic [1:0]                 ddr_part_wr,
  output logic [ADDR_WIDTH-1:0]      ddr_waddr,
  output logic [LEN_WIDTH-1:0]       ddr_wr_len,
  output logic                       ddr_wr_req,
  input  logic                       ddr_wdata_req,
  output logic [8*DQ_WIDTH-1:0]      ddr_wdata,
  input  logic                       ddr_wdone,
  output logic [FRAME_CNT_WIDTH-1:0] wr_frame_cnt,
  output logic                       overflow
);

  localparam int BEAT_W      = 8 * DQ_WIDTH;
  localparam int BEAT_PIX    = BEAT_W / PIX_WIDTH;
  localparam int LINE_BEATS  = H_NUM / BEAT_PIX;
  localparam int LINE_STRIDE = LINE_BEATS * 8;
  localparam int PCW = (BEAT_PIX > 1) ? $clog2(BEAT_PIX) : 1;
  localparam int BCW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int LIW = (V_NUM > 1) ? $clog2(V_NUM) : 1;

  localparam logic [PCW-1:0] LAST_PIX  = PCW'(BEAT_PIX - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(LINE_BEATS - 1);
  localparam logic [LIW-1:0] LAST_LINE = LIW'(V_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BURST,
    S_DONE
  } state_e;

  logic [BEAT_W-1:0]          mem_q [2][LINE_BEATS];

  logic                       vs_q;
  logic [PCW-1:0]             pix_cnt_q;
  logic [BCW-1:0]             beat_cnt_q;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic                       fill_q;
  logic                       ovf_q;

  state_e                     state_q, state_d;
  logic [1:0]                 full_q, full_d;
  logic                       drain_q, drain_d;
  logic [LIW-1:0]             line_idx_q, line_idx_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d;
  logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
  logic                       wr_req_q, wr_req_d;
  logic [BCW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [BEAT_W-1:0]          rdata_q;

  logic                       vs_rise;
  logic                       pix_acc;
  logic [PIX_WIDTH-1:0]       pix_val;
  logic                       beat_done;
  logic                       line_done;
  logic                       bank_free;
  logic                       ram_we;
  logic                       line_keep;
  logic                       rd_en;
  logic [LINE_ADDR_WIDTH-1:0] line_off;
  logic [ADDR_WIDTH-1:0]      next_addr;

  assign vs_rise = pix_vs && !vs_q;
  assign pix_acc = pix_de && !vs_rise;

`ifdef TEST_PATTERN_EN
  logic [7:0] in_line_q;
  logic [7:0] x_idx;
  logic       unused_pix;

  assign x_idx      = 8'(beat_cnt_q) * 8'(BEAT_PIX) + 8'(pix_cnt_q);
  assign pix_val    = PIX_WIDTH'({in_line_q, x_idx});
  assign unused_pix = ^pix_data;

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      in_line_q <= '0;
    end else if (vs_rise) begin
      in_line_q <= '0;
    end else if (line_done) begin
      in_line_q <= in_line_q + 8'd1;
    end
  end
`else
  assign pix_val = pix_data;
`endif

  always_comb begin
    beat_d = beat_q;
    beat_d[pix_cnt_q*PIX_WIDTH +: PIX_WIDTH] = pix_val;
  end

  assign beat_done = pix_acc && (pix_cnt_q == LAST_PIX);
  assign line_done = beat_done && (beat_cnt_q == LAST_BEAT);
  // A bank being released by DONE this cycle may be refilled right away.
  assign bank_free = !full_q[fill_q] ||
                     (state_q == S_DONE && drain_q == fill_q);
  assign ram_we    = beat_done && bank_free;
  assign line_keep = line_done && bank_free;

  always_ff @(posedge ddr_clk) begin
    if (ram_we) begin
      mem_q[fill_q][beat_cnt_q] <= beat_d;
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      vs_q       <= 1'b0;
      pix_cnt_q  <= '0;
      beat_cnt_q <= '0;
      beat_q     <= '0;
      fill_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      vs_q <= pix_vs;
      if (vs_rise) begin
        pix_cnt_q  <= '0;
        beat_cnt_q <= '0;
      end else if (pix_acc) begin
        beat_q    <= beat_d;
        pix_cnt_q <= beat_done ? '0 : pix_cnt_q + 1'b1;
        if (beat_done) begin
          beat_cnt_q <= line_done ? '0 : beat_cnt_q + 1'b1;
        end
        if (line_keep) begin
          fill_q <= ~fill_q;
        end else if (line_done) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign line_off  = LINE_ADDR_WIDTH'(line_idx_q) *
                     LINE_ADDR_WIDTH'(LINE_STRIDE);
  assign next_addr = ADDR_WIDTH'({frame_q[0], ddr_part_wr, line_off}) +
                     ADDR_WIDTH'(ADDR_OFFSET);

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    drain_d    = drain_q;
    line_idx_d = line_idx_q;
    frame_d    = frame_q;
    waddr_d    = waddr_q;
    wr_req_d   = wr_req_q;
    rd_ptr_d   = rd_ptr_q;
    rd_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        rd_ptr_d = '0;
        if (full_q[drain_q]) begin
          waddr_d  = next_addr;
          wr_req_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        rd_en = ddr_wdata_req;
        if (ddr_wdata_req) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        rd_en = ddr_wdata_req;
        if (ddr_wdone) begin
          wr_req_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        full_d[drain_q] = 1'b0;
        drain_d         = ~drain_q;
        if (line_idx_q == LAST_LINE) begin
          line_idx_d = '0;
          frame_d    = frame_q + 1'b1;
        end else begin
          line_idx_d = line_idx_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rd_en && rd_ptr_q != LAST_BEAT) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (line_keep) begin
      full_d[fill_q] = 1'b1;
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      state_q    <= S_IDLE;
      full_q     <= '0;
      drain_q    <= 1'b0;
      line_idx_q <= '0;
      frame_q    <= '0;
      waddr_q    <= ADDR_WIDTH'(ADDR_OFFSET);
      wr_req_q   <= 1'b0;
      rd_ptr_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      drain_q    <= drain_d;
      line_idx_q <= line_idx_d;
      frame_q    <= frame_d;
      waddr_q    <= waddr_d;
      wr_req_q   <= wr_req_d;
      rd_ptr_q   <= rd_ptr_d;
      if (rd_en) begin
        rdata_q <= mem_q[drain_q][rd_ptr_q];
      end
    end
  end

  assign ddr_waddr    = waddr_q;
  assign ddr_wr_len   = LEN_WIDTH'(LINE_BEATS);
  assign ddr_wr_req   = wr_req_q;
  assign ddr_wdata    = rdata_q;
  assign wr_frame_cnt = frame_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_frame_wr_buf.sv
// Bench for frame_wr_buf: small geometry, bench acts as pixel source and DDR controller.
// Expected beats are packed by the bench into a queue and popped as the DUT presents them.
module tb_frame_wr_buf;

  localparam int          H   = 128;
  localparam int          V   = 4;
  localparam int          BP  = 16;
  localparam int          LB  = H / BP;
  localparam logic [31:0] OFS = 32'h100;

  logic         clk = 1'b0;
  logic         rst;
  logic         vs;
  logic         de;
  logic [15:0]  pd;
  logic [1:0]   part;
  logic [26:0]  waddr;
  logic [15:0]  wlen;
  logic         wreq;
  logic         wdreq;
  logic [255:0] wdata;
  logic         wdone;
  logic [7:0]   fcnt;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int gline    = 0;
  int in_line  = 0;
  logic [255:0] exp_q[$];

  typedef struct {
    logic [1:0]  part;
    int          mode;
    logic [26:0] addr;
    logic [7:0]  frame;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  frame_wr_buf #(
    .ADDR_OFFSET (OFS),
    .H_NUM       (H),
    .V_NUM       (V)
  ) dut (
    .ddr_clk       (clk),
    .ddr_rst       (rst),
    .pix_vs        (vs),
    .pix_de        (de),
    .pix_data      (pd),
    .ddr_part_wr   (part),
    .ddr_waddr     (waddr),
    .ddr_wr_len    (wlen),
    .ddr_wr_req    (wreq),
    .ddr_wdata_req (wdreq),
    .ddr_wdata     (wdata),
    .ddr_wdone     (wdone),
    .wr_frame_cnt  (fcnt),
    .overflow      (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic vs_pulse();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    in_line = 0;
  endtask

  task automatic drive_line(input int npix, input bit push);
    logic [255:0] b;
    logic [15:0]  p;
    logic [15:0]  e;
    logic [7:0]   tag;
    tag = 8'(gline * 37 + 5);
    gline++;
    b = '0;
    for (int x = 0; x < npix; x++) begin
      p = {tag, 8'(x)};
`ifdef TEST_PATTERN_EN
      e = {8'(in_line), 8'(x)};
`else
      e = p;
`endif
      b[(x % BP)*16 +: 16] = e;
      if (push && (x % BP) == BP - 1) exp_q.push_back(b);
      de = 1'b1;
      pd = p;
      tick();
    end
    de = 1'b0;
    pd = '0;
    if (npix == H) in_line++;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (wreq !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("wr_req_seen", wreq, 1'b1);
  endtask

  task automatic pop_exp(output logic [255:0] e);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_underflow got=empty want=beat");
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  // mode 0: continuous, 1: sparse single pulses, 2: continuous + 2 extra
  task automatic serve(input logic [26:0] ea, input int mode);
    logic [255:0] last;
    logic [255:0] e;
    int nreq;
    wait_req();
    chk("waddr", waddr, ea);
    chk("wr_len", wlen, LB);
    nreq = (mode == 2) ? LB + 2 : LB;
    last = '0;
    for (int i = 0; i < nreq; i++) begin
      if (mode == 1 && i > 0) begin
        tick();
        tick();
        chk("beat_gap_hold", wdata, last);
      end
      wdreq = 1'b1;
      tick();
      if (mode == 1) wdreq = 1'b0;
      if (i < LB) begin
        pop_exp(e);
        chk("beat", wdata, e);
        last = e;
      end else begin
        chk("beat_ptr_hold", wdata, last);
      end
    end
    wdreq = 1'b0;
    wdone = 1'b1;
    tick();
    wdone = 1'b0;
    chk("wr_req_fall", wreq, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] e;
    tbl[0] = '{2'b00, 0, 27'h000_0100, 8'd0};
    tbl[1] = '{2'b01, 1, 27'h040_0140, 8'd0};
    tbl[2] = '{2'b01, 2, 27'h040_0180, 8'd0};
    tbl[3] = '{2'b10, 1, 27'h080_01C0, 8'd1};
    tbl[4] = '{2'b01, 0, 27'h140_0100, 8'd1};

    rst   = 1'b1;
    vs    = 1'b0;
    de    = 1'b0;
    pd    = '0;
    part  = 2'b00;
    wdreq = 1'b0;
    wdone = 1'b0;
    repeat (3) tick();
    chk("rst_wr_req", wreq, 1'b0);
    chk("rst_wdata", wdata, '0);
    chk("rst_waddr", waddr, 27'(OFS));
    chk("rst_frame", fcnt, 8'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_len", wlen, LB);
    rst = 1'b0;
    tick();
    vs_pulse();

    for (int i = 0; i < 5; i++) begin
      part = tbl[i].part;
      drive_line(H, 1'b1);
      chk("lat_cycle1", wreq, 1'b0);
      tick();
      chk("lat_cycle2", wreq, 1'b1);
      serve(tbl[i].addr, tbl[i].mode);
      chk("frame_cnt", fcnt, tbl[i].frame);
    end

    part = 2'b00;
    drive_line(H, 1'b1);
    drive_line(H, 1'b1);
    chk("ovf_two_lines", ovf, 1'b0);
    drive_line(H, 1'b0);
    tick();
    chk("ovf_third_line", ovf, 1'b1);
    serve(27'h100_0140, 0);
    serve(27'h100_0180, 1);
    repeat (20) tick();
    chk("dropped_no_req", wreq, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    drive_line(H, 1'b1);
    drive_line(60, 1'b0);
    vs_pulse();
    drive_line(H, 1'b1);
    serve(27'h100_01C0, 0);
    chk("frame_wrap2", fcnt, 8'd2);
    serve(27'h000_0100, 0);
    chk("frame_after_vs", fcnt, 8'd2);

    drive_line(H, 1'b1);
    wait_req();
    for (int i = 0; i < 3; i++) begin
      wdreq = 1'b1;
      tick();
      pop_exp(e);
      chk("pre_rst_beat", wdata, e);
    end
    wdreq = 1'b0;
    chk("ovf_sticky", ovf, 1'b1);
    rst = 1'b1;
    tick();
    chk("brst_wr_req", wreq, 1'b0);
    chk("brst_frame", fcnt, 8'd0);
    chk("brst_ovf", ovf, 1'b0);
    chk("brst_wdata", wdata, '0);
    chk("brst_waddr", waddr, 27'(OFS));
    rst = 1'b0;
    exp_q.delete();
    in_line = 0;
    tick();

    for (int i = 0; i < 4; i++) begin
      drive_line(H, 1'b1);
      serve(27'(OFS) + 27'(i * 64), 0);
      chk("post_rst_frame", fcnt, (i == 3) ? 8'd1 : 8'd0);
    end
    chk("sb_empty_end", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
